// File: rtl/fast_sr_aq_pkg.sv
// Shared word layout, FSM states and word builder for the fast shift-register acquisition core.
package fast_sr_aq_pkg;

    localparam int ID_MSB    = 31;
    localparam int ID_LSB    = 28;
    localparam int LAST_BIT  = 27;
    localparam int NBITS_MSB = 20;
    localparam int NBITS_LSB = 16;
    localparam int PAYLOAD_W = 16;
    localparam int CNT_W     = 5;
    localparam int WORD_W    = 32;

    typedef enum logic {IDLE, ACQ} state_t;

    function automatic logic [WORD_W-1:0] make_word(
        input logic [3:0]           id,
        input logic                 last,
        input logic [CNT_W-1:0]     nbits,
        input logic [PAYLOAD_W-1:0] payload
    );
        logic [WORD_W-1:0] w;
        w                       = '0;
        w[ID_MSB:ID_LSB]        = id;
        w[LAST_BIT]             = last;
        w[NBITS_MSB:NBITS_LSB]  = nbits;
        w[PAYLOAD_W-1:0]        = payload;
        return w;
    endfunction

endpackage

// File: rtl/fast_sr_aq_fifo.sv
// Single-clock first-word fall-through buffer; a pop in the same cycle frees room for a push when full.
module fast_sr_aq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       rd,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic                        do_rd, do_wr;

    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_rd)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fast_sr_aq_core.sv
// Samples the returned pixel shift-register stream, packs tagged 16-bit words and buffers them for the arbiter.
// Define FAST_SR_AQ_LOST_CNT_EN to build the saturating dropped-word counter on LOST_COUNT.
module fast_sr_aq_core
    import fast_sr_aq_pkg::*;
#(
    parameter logic [3:0] IDENTIFIER = 4'b0101,
    parameter int         DEPTH      = 8
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic        EN,
    input  logic        SR_CLK_IN,
    input  logic        SR_DATA,
    input  logic        FRAME_END,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic [31:0] FIFO_DATA,
    output logic [7:0]  LOST_COUNT
);
    state_t                 state;
    logic                   clk_q, clk_qq, data_q;
    logic [CNT_W-1:0]       cnt, nc;
    logic [PAYLOAD_W-1:0]   sr, ns;
    logic                   take;
    logic                   push_vld;
    logic [WORD_W-1:0]      push_word;
    logic                   full;
    logic [$clog2(DEPTH):0] fifo_count;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            clk_q  <= 1'b0;
            clk_qq <= 1'b0;
            data_q <= 1'b0;
        end else begin
            clk_q  <= SR_CLK_IN;
            clk_qq <= clk_q;
            data_q <= SR_DATA;
        end
    end

    // Bits are placed left-aligned as they arrive, so a partial word needs no final shift.
    assign take = (state == ACQ) & EN & clk_q & ~clk_qq;
    assign nc   = cnt + CNT_W'(take);
    assign ns   = take ? (sr | (PAYLOAD_W'(data_q) << (4'd15 - cnt[3:0]))) : sr;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            push_vld  <= 1'b0;
            push_word <= '0;
        end else begin
            push_vld <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    sr  <= '0;
                    if (EN)
                        state <= ACQ;
                end
                ACQ: begin
                    if (!EN) begin
                        // Falling enable: an edge in this cycle is dropped, only earlier bits flush.
                        if (cnt != '0) begin
                            push_vld  <= 1'b1;
                            push_word <= make_word(IDENTIFIER, 1'b1, cnt, sr);
                        end
                        cnt   <= '0;
                        sr    <= '0;
                        state <= IDLE;
                    end else if (FRAME_END || nc == CNT_W'(PAYLOAD_W)) begin
                        if (nc != '0) begin
                            push_vld  <= 1'b1;
                            push_word <= make_word(IDENTIFIER, FRAME_END, nc, ns);
                        end
                        cnt <= '0;
                        sr  <= '0;
                    end else begin
                        cnt <= nc;
                        sr  <= ns;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fast_sr_aq_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_fifo (
        .clk   (CLK),
        .rst_n (RST_B),
        .wr    (push_vld),
        .wdata (push_word),
        .rd    (FIFO_READ),
        .rdata (FIFO_DATA),
        .full  (full),
        .empty (FIFO_EMPTY),
        .count (fifo_count)
    );

`ifdef FAST_SR_AQ_LOST_CNT_EN
    logic       drop;
    logic [7:0] lost_cnt;
    logic       count_unused;

    assign count_unused = ^fifo_count;
    assign drop         = push_vld & full & ~(FIFO_READ & ~FIFO_EMPTY);

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B)
            lost_cnt <= '0;
        else if (drop && lost_cnt != 8'hFF)
            lost_cnt <= lost_cnt + 8'd1;
    end
    assign LOST_COUNT = lost_cnt;
`else
    logic fifo_unused;
    assign fifo_unused = ^{full, fifo_count};
    assign LOST_COUNT  = '0;
`endif

endmodule
